// File: rtl/uart_cmd_parser.sv
// UART command-frame parser: decodes write (header, address, payload) and read
// (header, address) frames from a byte stream and drives the write FIFO and trigger pulses.
module uart_cmd_parser #(
  parameter logic [7:0] WR_CMD      = 8'h55,
  parameter logic [7:0] RD_CMD      = 8'hAA,
  parameter int         ADDR_BYTES  = 2,
  parameter int         WR_BYTES    = 4,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_flag,
  input  logic [7:0]              uart_data,
  output logic                    wr_trig,
  output logic                    rd_trig,
  output logic [8*ADDR_BYTES-1:0] cmd_addr,
  output logic                    wfifo_wr_en,
  output logic [7:0]              wfifo_data,
  output logic                    busy,
  output logic                    err_flag
);

  // state | meaning
  // IDLE  | waiting for a header byte
  // ADDR  | collecting address bytes, MSB first
  // DATA  | collecting payload bytes of a write frame

  localparam int AW        = 8 * ADDR_BYTES;
  localparam int MAX_BYTES = (ADDR_BYTES > WR_BYTES) ? ADDR_BYTES : WR_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES) + 1;
  localparam int TMO_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WR_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  typedef enum logic {
    MODE_WR,
    MODE_RD
  } mode_t;

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW-1:0]     addr_shift;
  logic              wr_pend_q, wr_pend_d;
  logic              last_push;

  logic              wr_trig_d;
  logic              rd_trig_d;
  logic [AW-1:0]     cmd_addr_d;
  logic              wfifo_wr_en_d;
  logic [7:0]        wfifo_data_d;
  logic              busy_d;
  logic              err_flag_d;

  assign addr_shift = (addr_q << 8) | AW'(uart_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_WR;
      byte_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      addr_q      <= '0;
      wr_pend_q   <= 1'b0;
      wr_trig     <= 1'b0;
      rd_trig     <= 1'b0;
      cmd_addr    <= '0;
      wfifo_wr_en <= 1'b0;
      wfifo_data  <= '0;
      busy        <= 1'b0;
      err_flag    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      addr_q      <= addr_d;
      wr_pend_q   <= wr_pend_d;
      wr_trig     <= wr_trig_d;
      rd_trig     <= rd_trig_d;
      cmd_addr    <= cmd_addr_d;
      wfifo_wr_en <= wfifo_wr_en_d;
      wfifo_data  <= wfifo_data_d;
      busy        <= busy_d;
      err_flag    <= err_flag_d;
    end
  end

  // wr_pend delays the write trigger one cycle so it lands after the last FIFO push;
  // tmo_cnt reloads on every accepted byte and expires at zero when no byte arrives.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    byte_cnt_d    = byte_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    addr_d        = addr_q;
    wr_pend_d     = 1'b0;
    last_push     = 1'b0;
    wr_trig_d     = wr_pend_q;
    rd_trig_d     = 1'b0;
    cmd_addr_d    = wr_pend_q ? addr_q : cmd_addr;
    wfifo_wr_en_d = 1'b0;
    wfifo_data_d  = wfifo_data;
    err_flag_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (uart_flag) begin
          if (uart_data == WR_CMD) begin
            mode_d    = MODE_WR;
            state_d   = ADDR;
            tmo_cnt_d = TMO_LOAD;
          end else if (uart_data == RD_CMD) begin
            mode_d    = MODE_RD;
            state_d   = ADDR;
            tmo_cnt_d = TMO_LOAD;
          end else begin
            err_flag_d = 1'b1;
          end
        end
      end

      ADDR: begin
        if (uart_flag) begin
          addr_d    = addr_shift;
          tmo_cnt_d = TMO_LOAD;
          if (byte_cnt_q == ADDR_LAST) begin
            if (mode_q == MODE_RD) begin
              cmd_addr_d = addr_shift;
              rd_trig_d  = 1'b1;
              state_d    = IDLE;
            end else begin
              state_d = DATA;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (tmo_cnt_q == '0) begin
          err_flag_d = 1'b1;
          state_d    = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
      end

      DATA: begin
        if (uart_flag) begin
          wfifo_wr_en_d = 1'b1;
          wfifo_data_d  = uart_data;
          tmo_cnt_d     = TMO_LOAD;
          if (byte_cnt_q == DATA_LAST) begin
            wr_pend_d = 1'b1;
            last_push = 1'b1;
            state_d   = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (tmo_cnt_q == '0) begin
          err_flag_d = 1'b1;
          state_d    = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_d != state_q) byte_cnt_d = '0;

    // a finished write frame stays busy until its trigger cycle
    busy_d = (state_d != IDLE) || last_push;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Parametrised UART command-frame parser between the UART receiver and the SDRAM write FIFO / read-write arbiter. It accepts a byte stream (one byte per `uart_flag` strobe) and decodes two frame types:
- Write frames: header, address, payload. Payload bytes are pushed to the write FIFO.
- Read frames: header, address.

It adds what the fixed 0x55/0xAA decoder lacks: configurable header codes, address and payload lengths, a decoded address output, an inter-byte timeout, and error reporting.

## Interface
Parameters:
- WR_CMD, 8'h55, write-frame header byte
- RD_CMD, 8'hAA, read-frame header byte
- ADDR_BYTES, 2, address bytes per frame, MSB first (legal range 1..4)
- WR_BYTES, 4, payload bytes per write frame (legal range 1..1024)
- TIMEOUT_CYC, 50000, maximum clk cycles allowed between bytes inside a frame (≥2)

Ports:
- clk  input  1  system clock; single clock domain
- rst  input  1  asynchronous, active-high reset
- uart_flag  input  1  one-cycle strobe; uart_data is valid in this cycle
- uart_data  input  8  received byte
- wr_trig  output  1  one-cycle pulse: a write frame completed
- rd_trig  output  1  one-cycle pulse: a read frame completed
- cmd_addr  output  8*ADDR_BYTES  address of the last completed frame
- wfifo_wr_en  output  1  write-FIFO push strobe
- wfifo_data  output  8  write-FIFO data, valid while wfifo_wr_en=1
- busy  output  1  high while a frame is in progress (state ADDR or DATA)
- err_flag  output  1  one-cycle pulse on a bad header or on timeout

## Operation
- States:
  - IDLE: waiting for a header byte.
  - ADDR: collecting address bytes.
  - DATA: collecting payload bytes (write frames only).
- A `mode` register latched at the header holds wr or rd.
- Transitions on `uart_flag`:
  - IDLE:
    - Byte = WR_CMD: mode=wr, go to ADDR.
    - Byte = RD_CMD: mode=rd, go to ADDR.
    - Any other byte: pulse err_flag, stay in IDLE.
  - ADDR: shift the byte into an internal address register (MSB first) and increment the byte counter. On byte ADDR_BYTES:
    - mode=rd: load cmd_addr, pulse rd_trig, go to IDLE.
    - mode=wr: go to DATA.
  - DATA: push the byte to the FIFO. On byte WR_BYTES: load cmd_addr, pulse wr_trig, go to IDLE.
- Header bytes are compared only in IDLE. A byte equal to WR_CMD or RD_CMD inside ADDR or DATA is treated as ordinary data.
- Byte counter:
  - Width is $clog2 of the larger of ADDR_BYTES and WR_BYTES, plus 1.
  - Cleared on every state change.
- Timeout counter:
  - Runs only in ADDR or DATA.
  - Cleared on every uart_flag and on entry to ADDR.
  - On reaching TIMEOUT_CYC-1: pulse err_flag, go to IDLE. No trig pulse. cmd_addr is unchanged.
  - FIFO bytes already pushed are not retracted. The downstream block must ignore FIFO contents until wr_trig.
- cmd_addr changes only when a frame completes and holds until the next completion.

## Timing
- Reset (async assert, sync release): state IDLE. wr_trig, rd_trig, wfifo_wr_en, err_flag, busy are 0. cmd_addr and wfifo_data are 0. All counters are 0.
- All outputs are registered.
- Let cycle N be the uart_flag cycle:
  - Payload byte: wfifo_wr_en=1 and wfifo_data=byte in cycle N+1.
  - Last payload byte: wr_trig=1 in N+2, one cycle after the last FIFO push. cmd_addr is valid from N+2.
  - Last address byte of a read frame: rd_trig=1 and cmd_addr valid in N+1.
  - Bad header: err_flag=1 in N+1.
  - Header byte: busy rises in N+1.
  - Frame completion or timeout: busy falls in the cycle the trig or err pulse is driven.
- Back-to-back strobes are legal; one byte per cycle is accepted with no stall.
- After a completed write frame, a new header may arrive in cycle N+1; it is decoded normally.
- If uart_flag arrives in the same cycle the timeout count reaches TIMEOUT_CYC-1, the byte wins: it is accepted and there is no error.
- Timeout expiry with no byte: err_flag pulses in the cycle after the count reaches TIMEOUT_CYC-1.
- Reset asserted mid-frame: immediate return to IDLE. No trig or err pulse. Any wfifo_wr_en in flight is dropped.

## Test plan
- Write frame, defaults: bytes 55 12 34 56 78 9A BC, spaced 20 cycles.
  - Exactly 4 wfifo_wr_en pulses carrying 56, 78, 9A, BC.
  - wr_trig one cycle after the BC push, with cmd_addr=16'h1234.
  - busy covers the frame; err_flag stays 0.
- Read frame back-to-back: AA 00 07 on consecutive cycles.
  - rd_trig one cycle after 07; cmd_addr=16'h0007.
  - No wfifo_wr_en.
- Bad header and in-frame header value: bytes 3C, then 55 AA 55 AA AA 55 AA.
  - err_flag pulse for 3C.
  - Address 16'hAA55; payload AA AA 55 AA.
  - wr_trig pulses; no rd_trig.
- Timeout, TIMEOUT_CYC=100: bytes 55 12, then silence.
  - err_flag exactly 100 cycles after the 12 strobe; busy falls.
  - No wr_trig; cmd_addr unchanged.
  - Next frame AA 00 01 yields rd_trig, cmd_addr=16'h0001.
  - Boundary: a byte landing on the expiry cycle is accepted.
- Reset mid-frame: assert rst after 55 12 34 56.
  - All outputs 0 immediately.
  - After release, a full read frame decodes correctly.
- Parameter sweep: ADDR_BYTES=1, WR_BYTES=1, WR_CMD=8'hF0.
  - Bytes F0 9C 42: one push of 42, wr_trig, cmd_addr=8'h9C.
